// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port for the fetch stage: one request channel and one response channel.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: owns the fetch PC, keeps at most one imem request outstanding,
// and holds the returned word in an instruction register until it is consumed.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instr_fetch_unit_if.master        imem,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      stall,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [6:0]                opcode,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic                      misaligned_fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN, FAULT} state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] pc_n, instr_n;
  logic        instr_valid_n, fault_n;
  logic        drain_fault, drain_fault_n;
  logic        redir_misaligned, rsp_pending;

  assign imem.imem_req_valid = (state == REQ);
  assign imem.imem_addr      = fetch_pc;
  assign opcode              = instr[6:0];
  assign pc_plus4            = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      fetch_pc         <= RESET_PC;
      pc               <= RESET_PC;
      instr            <= NOP_INSTR;
      instr_valid      <= 1'b0;
      misaligned_fault <= 1'b0;
      drain_fault      <= 1'b0;
    end else begin
      state            <= state_n;
      fetch_pc         <= fetch_pc_n;
      pc               <= pc_n;
      instr            <= instr_n;
      instr_valid      <= instr_valid_n;
      misaligned_fault <= fault_n;
      drain_fault      <= drain_fault_n;
    end
  end

  // A redirect that leaves a response in flight must drain it first; drain_fault
  // remembers whether the drain should end in FAULT rather than a new request.
  always_comb begin
    state_n          = state;
    fetch_pc_n       = fetch_pc;
    pc_n             = pc;
    instr_n          = instr;
    instr_valid_n    = instr_valid;
    fault_n          = misaligned_fault;
    drain_fault_n    = drain_fault;
    redir_misaligned = (redirect_pc[1:0] != 2'b00);
    rsp_pending      = ((state == REQ) && imem.imem_req_ready) ||
                       (((state == WAIT) || (state == DRAIN)) && !imem.imem_rsp_valid);

    if (state == IDLE) begin
      state_n = REQ;
    end else if (redirect_valid) begin
      fetch_pc_n    = redirect_pc;
      instr_valid_n = 1'b0;
      instr_n       = NOP_INSTR;
      if (rsp_pending) begin
        state_n       = DRAIN;
        drain_fault_n = redir_misaligned;
        fault_n       = 1'b0;
      end else if (redir_misaligned) begin
        state_n = FAULT;
        fault_n = 1'b1;
      end else begin
        state_n = REQ;
        fault_n = 1'b0;
      end
    end else begin
      case (state)
        REQ: begin
          if (imem.imem_req_ready) begin
            pc_n    = fetch_pc;
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            instr_n       = imem.imem_rsp_data;
            instr_valid_n = 1'b1;
            state_n       = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_valid_n = 1'b0;
            instr_n       = NOP_INSTR;
            fetch_pc_n    = pc_plus4;
            state_n       = REQ;
          end
        end
        DRAIN: begin
          if (imem.imem_rsp_valid) begin
            drain_fault_n = 1'b0;
            if (drain_fault) begin
              state_n = FAULT;
              fault_n = 1'b1;
            end else begin
              state_n = REQ;
            end
          end
        end
        FAULT: begin
          state_n = FAULT;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a table of fetched words plus hand-written redirect,
// fault, wrap and reset sequences, with a scoreboard of expected {pc, instr}.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned_fault;

  instr_fetch_unit_if ifc();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (ifc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .stall            (stall),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .opcode           (opcode),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .misaligned_fault (misaligned_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  typedef struct {
    logic [31:0] data;
    int          stall_cycles;
    logic [6:0]  exp_opcode;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  bit          auto_rsp;
  bit          prev_valid;
  logic [31:0] next_data;
  logic [31:0] model_pc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic st, input logic rdy);
    redirect_valid     = rv;
    redirect_pc        = rpc;
    stall              = st;
    ifc.imem_req_ready = rdy;
  endtask

  // One clock: model memory answers an accepted request on the next cycle,
  // and a rising instr_valid is matched against the scoreboard.
  task automatic tick();
    logic        hs;
    logic [31:0] hs_addr;
    sb_t         e;
    hs      = ifc.imem_req_valid && ifc.imem_req_ready;
    hs_addr = ifc.imem_addr;
    @(posedge clk);
    #1;
    ifc.imem_rsp_valid = 1'b0;
    if (hs) begin
      checkOutput("req_addr", hs_addr, model_pc);
      if (auto_rsp) begin
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = next_data;
        sb_q.push_back('{pc: model_pc, instr: next_data});
      end
    end
    if (instr_valid && !prev_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_instr: got instr_valid=1 instr=%h expected no instruction", instr);
      end else begin
        e = sb_q.pop_front();
        checks--;
        checkOutput("sb_instr", instr, e.instr);
        checkOutput("sb_pc", pc, e.pc);
        checkOutput("sb_opcode", {25'd0, opcode}, {25'd0, e.instr[6:0]});
        checkOutput("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
      end
    end
    prev_valid = instr_valid;
  endtask

  task automatic wait_instr(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (!instr_valid) begin
      errors++;
      $display("[TB] FAIL %s: got no instr_valid within 8 cycles expected instr_valid=1", name);
    end
  endtask

  task automatic consume();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    model_pc = model_pc + 32'd4;
    checkOutput("req_after_consume", {31'd0, ifc.imem_req_valid}, 32'd1);
    checkOutput("valid_after_consume", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    int reqs;
    vecs[0] = '{32'h0050_0093, 0, 7'h13};
    vecs[1] = '{32'h00a0_0113, 5, 7'h13};
    vecs[2] = '{32'h0020_81b3, 0, 7'h33};
    vecs[3] = '{32'h0000_a203, 2, 7'h03};
    vecs[4] = '{32'h0000_0297, 0, 7'h17};
    vecs[5] = '{32'h0100_006f, 1, 7'h6f};

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = 32'h0;
    auto_rsp   = 1'b1;
    prev_valid = 1'b0;
    model_pc   = RESET_PC;
    next_data  = NOP;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_valid", {31'd0, ifc.imem_req_valid}, 32'd0);
    checkOutput("rst_instr", instr, NOP);
    checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    checkOutput("rst_fault", {31'd0, misaligned_fault}, 32'd0);
    checkOutput("rst_addr", ifc.imem_addr, RESET_PC);

    rst_n = 1'b1;
    checkOutput("idle_no_req", {31'd0, ifc.imem_req_valid}, 32'd0);
    tick();
    checkOutput("first_req", {31'd0, ifc.imem_req_valid}, 32'd1);
    checkOutput("first_addr", ifc.imem_addr, RESET_PC);

    for (int i = 0; i < 6; i++) begin
      next_data = vecs[i].data;
      wait_instr("vec_fetch");
      checkOutput("vec_opcode", {25'd0, opcode}, {25'd0, vecs[i].exp_opcode});
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      for (int s = 0; s < vecs[i].stall_cycles; s++) begin
        tick();
        checkOutput("stall_instr", instr, vecs[i].data);
        checkOutput("stall_pc", pc, model_pc);
        checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("stall_no_req", {31'd0, ifc.imem_req_valid}, 32'd0);
      end
      consume();
    end

    // Redirect while waiting: the late response must be dropped.
    auto_rsp = 1'b0;
    tick();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    model_pc = 32'h100;
    checkOutput("drain_no_req", {31'd0, ifc.imem_req_valid}, 32'd0);
    checkOutput("drain_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    tick();
    checkOutput("drain_still_no_req", {31'd0, ifc.imem_req_valid}, 32'd0);
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hdead_beef;
    tick();
    checkOutput("drain_drop_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("drain_then_req", {31'd0, ifc.imem_req_valid}, 32'd1);
    checkOutput("drain_then_addr", ifc.imem_addr, 32'h100);
    auto_rsp = 1'b1;

    // Misaligned redirect from a stalled HOLD.
    next_data = 32'h00c0_0193;
    wait_instr("fetch_0x100");
    applyStimulus(1'b1, 32'h102, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("fault_set", {31'd0, misaligned_fault}, 32'd1);
    checkOutput("fault_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("fault_instr_nop", instr, NOP);
    reqs = 0;
    repeat (10) begin
      tick();
      if (ifc.imem_req_valid) reqs++;
    end
    checkOutput("fault_no_req", reqs, 0);
    checkOutput("fault_held", {31'd0, misaligned_fault}, 32'd1);
    applyStimulus(1'b1, 32'h301, 1'b0, 1'b1);
    tick();
    checkOutput("fault_refault", {31'd0, misaligned_fault}, 32'd1);
    checkOutput("fault_refault_no_req", {31'd0, ifc.imem_req_valid}, 32'd0);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
    tick();
    model_pc = 32'h200;
    checkOutput("fault_clear", {31'd0, misaligned_fault}, 32'd0);
    checkOutput("fault_clear_req", {31'd0, ifc.imem_req_valid}, 32'd1);
    checkOutput("fault_clear_addr", ifc.imem_addr, 32'h200);

    // Redirect while the request is unaccepted, then wrap at the top of memory.
    applyStimulus(1'b1, 32'hffff_fffc, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    model_pc = 32'hffff_fffc;
    checkOutput("wrap_addr", ifc.imem_addr, 32'hffff_fffc);
    next_data = 32'h0000_0073;
    wait_instr("fetch_top");
    checkOutput("wrap_pc_plus4", pc_plus4, 32'h0);
    consume();
    checkOutput("wrap_next_addr", ifc.imem_addr, 32'h0);

    // Misaligned redirect with a request just accepted drains before faulting.
    auto_rsp = 1'b0;
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("dfault_pending", {31'd0, misaligned_fault}, 32'd0);
    checkOutput("dfault_no_req", {31'd0, ifc.imem_req_valid}, 32'd0);
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'h1234_5678;
    tick();
    checkOutput("dfault_set", {31'd0, misaligned_fault}, 32'd1);
    checkOutput("dfault_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    model_pc = 32'h0;
    checkOutput("dfault_clear", {31'd0, misaligned_fault}, 32'd0);
    checkOutput("dfault_req", {31'd0, ifc.imem_req_valid}, 32'd1);

    // Reset during WAIT, then a stale response after release.
    tick();
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    prev_valid = 1'b0;
    checkOutput("mid_rst_req", {31'd0, ifc.imem_req_valid}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("mid_rst_addr", ifc.imem_addr, RESET_PC);
    tick();
    rst_n = 1'b1;
    model_pc = RESET_PC;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hbad0_bad0;
    tick();
    checkOutput("post_rst_req", {31'd0, ifc.imem_req_valid}, 32'd1);
    checkOutput("post_rst_addr", ifc.imem_addr, RESET_PC);
    checkOutput("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hbad0_bad0;
    tick();
    checkOutput("stale_ignored", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    auto_rsp  = 1'b1;
    next_data = 32'h0010_0093;
    wait_instr("post_rst_fetch");
    consume();

    checkOutput("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction-fetch stage for the RV32 core. Owns the fetch PC, issues one request at a time to instruction memory over a valid/ready port, and holds the returned word in an instruction register. The opcode field from that register drives the downstream control unit's `opcode` input. Branch/jump redirects from the execute stage flush any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; must be 4-byte aligned.
- `NOP_INSTR`, default 32'h0000_0013: value the instruction register holds when empty (ADDI x0,x0,0).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_addr`  out  32  fetch address (= fetch_pc).
- `imem_rsp_valid`  in  1  response word valid this cycle.
- `imem_rsp_data`  in  32  response word.
- `redirect_valid`  in  1  taken branch/JAL/JALR this cycle.
- `redirect_pc`  in  32  new fetch target.
- `stall`  in  1  downstream cannot consume the held instruction.
- `instr_valid`  out  1  `instr` holds a live instruction.
- `instr`  out  32  instruction register.
- `opcode`  out  7  `instr[6:0]`, to the control unit.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32 (link value for JAL/JALR).
- `misaligned_fault`  out  1  redirect target not 4-byte aligned.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN, FAULT.
- IDLE: entered only from reset; unconditionally goes to REQ on the next edge.
- REQ: `imem_req_valid=1`, `imem_addr=fetch_pc`. On `imem_req_ready`, capture `pc<=fetch_pc` and go to WAIT.
- WAIT: on `imem_rsp_valid`, set `instr<=imem_rsp_data` and `instr_valid<=1`, then go to HOLD.
- HOLD: `instr` is stable. If `stall=0`, the instruction is consumed this cycle: set `instr_valid<=0`, `instr<=NOP_INSTR`, `fetch_pc<=pc+4`, and go to REQ.
- Redirect (`redirect_valid=1`) has priority over every other event in every state except IDLE.
  - Always load `fetch_pc<=redirect_pc`, clear `instr_valid`, and load `instr<=NOP_INSTR`.
  - From REQ without handshake, or from HOLD (including when `stall=1`): go to REQ. `imem_addr` may change while unaccepted only on a redirect.
  - From REQ with handshake in the same cycle, or from WAIT without response: go to DRAIN.
  - From WAIT with response in the same cycle: discard the response and go to REQ.
  - From DRAIN: stay in DRAIN with the new target.
- DRAIN: wait for `imem_rsp_valid`, discard the data, then go to REQ. At most one request is ever outstanding.
- Misaligned redirect (`redirect_pc[1:0]!=0`): go to FAULT and set `misaligned_fault<=1`. Exception: if a response is outstanding, go to DRAIN first; after the discard go to FAULT instead of REQ.
- FAULT: no requests; `misaligned_fault` holds. An aligned redirect clears the fault and goes to REQ. A further misaligned redirect stays in FAULT.
- `imem_rsp_valid` in IDLE, REQ, HOLD or FAULT is ignored.

## Timing
- Reset values: state=IDLE, `fetch_pc=RESET_PC`, `pc=RESET_PC`, `instr=NOP_INSTR`, `instr_valid=0`, `misaligned_fault=0`, `imem_req_valid=0`.
- `imem_req_valid` is a decode of state: high only in REQ. The first request appears in the 2nd cycle after `rst_n` rises (cycle 1 is IDLE).
- Latency: a response at edge t gives `instr_valid=1` from t+1 (registered).
- Zero-wait memory (ready=1, rsp the cycle after accept) gives one instruction every 3 cycles (REQ, WAIT, HOLD).
- `opcode`, `pc_plus4` and `imem_addr` are combinational from registers; no input-to-output combinational path except none (all outputs registered or state-decoded).
- Reset asserted mid-operation returns to the reset values immediately. Any response arriving after reset release while in IDLE/REQ is ignored.

## Test plan
- Reset, RESET_PC=0, ready=1, 1-cycle rsp of 32'h00500093 → req addr 0 in cycle 2; `instr_valid=1`, `opcode=7'h13`, `pc=0`, `pc_plus4=4` in cycle 4; next req addr 4.
- `stall=1` for 5 cycles in HOLD → `instr`, `pc` and `instr_valid` are unchanged and there are no requests; stall drops → one REQ at `pc+4`.
- Redirect to 32'h100 in WAIT, rsp 3 cycles later → response dropped and `instr_valid` stays 0; next req addr 32'h100.
- Redirect to 32'h102 in HOLD → `misaligned_fault=1` and no requests for 10 cycles; redirect to 32'h200 → fault clears and req addr 32'h200.
- `pc=32'hFFFF_FFFC` consumed → `pc_plus4=0`; next req addr 0 (wrap).
- `rst_n` low during WAIT, then release with a stale rsp → stale data ignored; first req at RESET_PC.
